blob_run_ctrl: RTL and testbench

Run controller for the blob-counting datapath. Arms the blob counter on command or continuously, and gives it exclusive use of the shared SDRAM pixel read port for one full frame. Converts the 8-bit luma stream to the 1-bit foreground sequence it consumes, then collects its result. Sits between the SDRAM read FIFO, the VGA reader, which shares the same port, and the blob counter; presents a stable count to the display overlay and seven-segment logic.

---
 rtl/blob_run_ctrl.sv | 164 ++++++++++++++++
 tb/tb_blob_run_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/blob_run_ctrl.sv
// rtl/blob_run_ctrl.sv - arms the blob counter for one frame on the shared SDRAM read port and collects its count
// Optional feature macro: BLOB_CTRL_COUNT_FILTER_EN (publish a count only when two consecutive runs agree)
module blob_run_ctrl #(
   parameter int PIXELS_PER_FRAME = 480000,
   parameter int TIMEOUT_CYCLES   = 4096
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_start,
   input  logic        i_auto,
   input  logic [7:0]  i_thresh,
   input  logic        i_vga_vblank,
   input  logic        i_vga_req,
   output logic        o_vga_gnt,
   input  logic        i_rd_valid,
   input  logic [15:0] i_rd_data,
   output logic        o_rd_req,
   output logic        o_blob_valid,
   output logic        o_blob_seq,
   input  logic        i_blob_sdram_req,
   input  logic        i_blob_done,
   input  logic [7:0]  i_blob_count,
   output logic [7:0]  o_count,
   output logic        o_count_valid,
   output logic        o_busy,
   output logic        o_underrun,
   output logic        o_timeout
);

   localparam int PCW = $clog2(PIXELS_PER_FRAME + 1);
   localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [PCW-1:0] PIX_LAST = PCW'(PIXELS_PER_FRAME - 1);
   localparam logic [TCW-1:0] TMO_LAST = TCW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_VB,
      S_ARM,
      S_STREAM,
      S_DRAIN,
      S_RELEASE
   } state_t;

   state_t         state;
   logic [7:0]     thresh_reg;
   logic [PCW-1:0] pix_cnt;
   logic [TCW-1:0] tmo_cnt;

`ifdef BLOB_CTRL_COUNT_FILTER_EN
   // Last completed count and whether it is still a valid link in the agreement chain
   logic [7:0]     prev_count;
   logic           prev_valid;
`endif

   // The VGA request never steers the FSM and the FIFO upper byte carries no luma
   logic unused_inputs;
   assign unused_inputs = &{1'b0, i_vga_req, i_rd_data[15:8]};

   // Pop and threshold the FIFO head only while streaming and the counter asks for a pixel;
   // a request against an empty FIFO sends a background (0) pixel
   always_comb begin
      o_rd_req   = (state == S_STREAM) && i_blob_sdram_req && i_rd_valid;
      o_blob_seq = o_rd_req && (i_rd_data[7:0] >= thresh_reg);
   end

   // Run sequencing, port ownership, pixel/timeout counting and result capture
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= S_IDLE;
         thresh_reg    <= '0;
         pix_cnt       <= '0;
         tmo_cnt       <= '0;
         o_vga_gnt     <= 1'b1;
         o_blob_valid  <= 1'b0;
         o_busy        <= 1'b0;
         o_underrun    <= 1'b0;
         o_timeout     <= 1'b0;
         o_count       <= '0;
         o_count_valid <= 1'b0;
`ifdef BLOB_CTRL_COUNT_FILTER_EN
         prev_count    <= '0;
         prev_valid    <= 1'b0;
`endif
      end else begin
         case (state)
            S_IDLE: begin
               if (i_start || i_auto) begin
                  state      <= S_WAIT_VB;
                  thresh_reg <= i_thresh;
                  pix_cnt    <= '0;
                  o_busy     <= 1'b1;
               end
            end
            S_WAIT_VB: begin
               // Port handover only inside vertical blank; sticky flags restart with the new run
               if (i_vga_vblank) begin
                  state        <= S_ARM;
                  o_vga_gnt    <= 1'b0;
                  o_blob_valid <= 1'b1;
                  o_underrun   <= 1'b0;
                  o_timeout    <= 1'b0;
               end
            end
            S_ARM: begin
               state <= S_STREAM;
            end
            S_STREAM: begin
               // Every request is one pixel of the frame, whether or not the FIFO had data
               if (i_blob_sdram_req) begin
                  if (!i_rd_valid) begin
                     o_underrun <= 1'b1;
                  end
                  if (pix_cnt == PIX_LAST) begin
                     state     <= S_DRAIN;
                     o_vga_gnt <= 1'b1;
                     tmo_cnt   <= '0;
                  end
                  pix_cnt <= pix_cnt + 1'b1;
               end
            end
            S_DRAIN: begin
               if (i_blob_done) begin
                  state        <= S_RELEASE;
                  o_blob_valid <= 1'b0;
`ifdef BLOB_CTRL_COUNT_FILTER_EN
                  if (prev_valid && (i_blob_count == prev_count)) begin
                     o_count       <= i_blob_count;
                     o_count_valid <= 1'b1;
                  end
                  prev_count <= i_blob_count;
                  prev_valid <= 1'b1;
`else
                  o_count       <= i_blob_count;
                  o_count_valid <= 1'b1;
`endif
               end else if (tmo_cnt == TMO_LAST) begin
                  state        <= S_RELEASE;
                  o_blob_valid <= 1'b0;
                  o_timeout    <= 1'b1;
`ifdef BLOB_CTRL_COUNT_FILTER_EN
                  prev_valid   <= 1'b0;
`endif
               end else begin
                  tmo_cnt <= tmo_cnt + 1'b1;
               end
            end
            S_RELEASE: begin
               // Wait for the counter to drop done so a stale done cannot end the next run
               if (!i_blob_done) begin
                  state  <= S_IDLE;
                  o_busy <= 1'b0;
               end
            end
            default: begin
               state        <= S_IDLE;
               o_vga_gnt    <= 1'b1;
               o_blob_valid <= 1'b0;
               o_busy       <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_blob_run_ctrl.sv
// tb/tb_blob_run_ctrl.sv - self-checking bench for blob_run_ctrl
module tb_blob_run_ctrl;

   localparam int PPF = 40;
   localparam int TMO = 16;
   localparam int M_TABLE = 0;
   localparam int M_FULL  = 1;
   localparam int M_UNDER = 2;
   localparam int M_RAND  = 3;
   localparam int NV = 8;

   logic        clk = 1'b0;
   logic        i_rst, i_start, i_auto, i_vga_vblank, i_vga_req, i_rd_valid;
   logic [7:0]  i_thresh, i_blob_count;
   logic [15:0] i_rd_data;
   logic        i_blob_sdram_req, i_blob_done;
   logic        o_vga_gnt, o_rd_req, o_blob_valid, o_blob_seq;
   logic [7:0]  o_count;
   logic        o_count_valid, o_busy, o_underrun, o_timeout;

   always #5 clk = ~clk;

   blob_run_ctrl #(.PIXELS_PER_FRAME(PPF), .TIMEOUT_CYCLES(TMO)) dut (
      .i_clk(clk), .i_rst(i_rst), .i_start(i_start), .i_auto(i_auto), .i_thresh(i_thresh),
      .i_vga_vblank(i_vga_vblank), .i_vga_req(i_vga_req), .o_vga_gnt(o_vga_gnt),
      .i_rd_valid(i_rd_valid), .i_rd_data(i_rd_data), .o_rd_req(o_rd_req),
      .o_blob_valid(o_blob_valid), .o_blob_seq(o_blob_seq), .i_blob_sdram_req(i_blob_sdram_req),
      .i_blob_done(i_blob_done), .i_blob_count(i_blob_count), .o_count(o_count),
      .o_count_valid(o_count_valid), .o_busy(o_busy), .o_underrun(o_underrun), .o_timeout(o_timeout)
   );

   typedef struct {
      bit       req;
      bit       valid;
      bit [7:0] luma;
      bit       exp_rd_req;
      bit       exp_seq;
   } vec_t;

   vec_t tbl [NV];

   int vectors = 0;
   int miscompares = 0;

   // Result model: what the display should show after the completed runs so far
   logic [7:0] exp_count;
   bit         exp_cv;
   bit         chain_valid;
   logic [7:0] chain_val;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_done(input logic [7:0] c);
`ifdef BLOB_CTRL_COUNT_FILTER_EN
      if (chain_valid && chain_val == c) begin
         exp_count = c;
         exp_cv    = 1'b1;
      end
      chain_valid = 1'b1;
      chain_val   = c;
`else
      exp_count = c;
      exp_cv    = 1'b1;
`endif
   endtask

   task automatic model_timeout();
      chain_valid = 1'b0;
   endtask

   task automatic model_reset();
      exp_count   = 8'h00;
      exp_cv      = 1'b0;
      chain_valid = 1'b0;
      chain_val   = 8'h00;
   endtask

   task automatic kick(input logic [7:0] th, input bit use_auto);
      @(negedge clk);
      check("idle_busy", o_busy, 0);
      i_thresh = th;
      if (use_auto) i_auto = 1'b1; else i_start = 1'b1;
      @(negedge clk);
      i_start  = 1'b0;
      i_auto   = 1'b0;
      i_thresh = ~th;
      check("wvb_busy", o_busy, 1);
      repeat (2) @(negedge clk);
      check("wvb_gnt", o_vga_gnt, 1);
      check("wvb_valid", o_blob_valid, 0);
      i_vga_vblank = 1'b1;
      @(negedge clk);
      i_vga_vblank = 1'b0;
      check("arm_gnt", o_vga_gnt, 0);
      check("arm_valid", o_blob_valid, 1);
      check("arm_underrun_clr", o_underrun, 0);
      check("arm_timeout_clr", o_timeout, 0);
   endtask

   // done_lat < 0 means the counter never reports done
   task automatic do_run(input int mode, input logic [7:0] th, input int done_lat,
                         input logic [7:0] cnt, input bit use_auto);
      int reqs = 0, cyc = 0, pops = 0, exp_pops = 0;
      bit under = 0;
      bit r, v;
      logic [7:0] l;
      kick(th, use_auto);
      while (reqs < PPF && cyc < PPF * 20) begin
         @(negedge clk);
         l = ($urandom_range(0, 3) == 0) ? th : 8'($urandom_range(0, 255));
         case (mode)
            M_TABLE: begin
               if (cyc < NV) begin r = tbl[cyc].req; v = tbl[cyc].valid; l = tbl[cyc].luma; end
               else begin r = 1'($urandom_range(0, 1)); v = 1'b1; end
            end
            M_FULL:  begin r = 1'b1; v = 1'b1; end
            M_UNDER: begin r = 1'b1; v = !(cyc >= 10 && cyc < 13); end
            default: begin r = ($urandom_range(0, 3) != 0); v = ($urandom_range(0, 7) != 0); end
         endcase
         i_blob_sdram_req = r;
         i_rd_valid       = v;
         i_rd_data        = {8'($urandom_range(0, 255)), l};
         i_start          = (cyc == 3);
         #1;
         if (mode == M_TABLE && cyc < NV) begin
            check("tbl_rd_req", o_rd_req, tbl[cyc].exp_rd_req);
            check("tbl_seq", o_blob_seq, tbl[cyc].exp_seq);
         end else begin
            check("rd_req", o_rd_req, r & v);
            check("seq", o_blob_seq, r & v & (l >= th));
         end
         check("stream_gnt", o_vga_gnt, 0);
         if (o_rd_req) pops++;
         if (r) begin
            reqs++;
            if (!v) under = 1;
            else exp_pops++;
         end
         cyc++;
      end
      if (reqs < PPF) check("stream_budget", reqs, PPF);
      @(negedge clk);
      i_start = 1'b0;
      i_blob_sdram_req = 1'b1;
      i_rd_valid = 1'b1;
      #1;
      check("drain_rd_req", o_rd_req, 0);
      check("drain_gnt", o_vga_gnt, 1);
      check("drain_valid", o_blob_valid, 1);
      check("pops", pops, exp_pops);
      check("underrun", o_underrun, under);
      i_blob_sdram_req = 1'b0;
      i_rd_valid = 1'b0;
      if (done_lat >= 0) begin
         repeat (done_lat) @(negedge clk);
         i_blob_done  = 1'b1;
         i_blob_count = cnt;
         @(negedge clk);
         model_done(cnt);
         check("rel_valid", o_blob_valid, 0);
         check("rel_count", o_count, exp_count);
         check("rel_count_valid", o_count_valid, exp_cv);
         check("rel_timeout", o_timeout, 0);
         @(negedge clk);
         check("rel_hold_busy", o_busy, 1);
         i_blob_done  = 1'b0;
         i_blob_count = ~cnt;
         @(negedge clk);
      end else begin
         repeat (TMO - 1) @(negedge clk);
         check("tmo_early", o_timeout, 0);
         check("tmo_busy", o_busy, 1);
         @(negedge clk);
         model_timeout();
         check("tmo_set", o_timeout, 1);
         check("tmo_count", o_count, exp_count);
         check("tmo_count_valid", o_count_valid, exp_cv);
         check("tmo_valid", o_blob_valid, 0);
         @(negedge clk);
      end
      check("end_busy", o_busy, 0);
      check("end_gnt", o_vga_gnt, 1);
      check("end_underrun", o_underrun, under);
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, "_gnt"}, o_vga_gnt, 1);
      check({tag, "_rd_req"}, o_rd_req, 0);
      check({tag, "_blob_valid"}, o_blob_valid, 0);
      check({tag, "_seq"}, o_blob_seq, 0);
      check({tag, "_busy"}, o_busy, 0);
      check({tag, "_underrun"}, o_underrun, 0);
      check({tag, "_timeout"}, o_timeout, 0);
      check({tag, "_count_valid"}, o_count_valid, 0);
      check({tag, "_count"}, o_count, 0);
   endtask

   initial begin
      tbl[0] = '{1'b1, 1'b1, 8'h80, 1'b1, 1'b1};
      tbl[1] = '{1'b1, 1'b1, 8'h7F, 1'b1, 1'b0};
      tbl[2] = '{1'b0, 1'b1, 8'hFF, 1'b0, 1'b0};
      tbl[3] = '{1'b1, 1'b0, 8'hFF, 1'b0, 1'b0};
      tbl[4] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1};
      tbl[5] = '{1'b1, 1'b1, 8'h00, 1'b1, 1'b0};
      tbl[6] = '{1'b0, 1'b0, 8'h80, 1'b0, 1'b0};
      tbl[7] = '{1'b1, 1'b1, 8'h81, 1'b1, 1'b1};

      model_reset();
      i_rst = 1'b1; i_start = 1'b0; i_auto = 1'b0; i_thresh = 8'h00;
      i_vga_vblank = 1'b0; i_vga_req = 1'b1; i_rd_valid = 1'b0; i_rd_data = 16'h0;
      i_blob_sdram_req = 1'b1; i_blob_done = 1'b0; i_blob_count = 8'h00;
      repeat (3) @(negedge clk);
      check_reset_state("reset");
      i_blob_sdram_req = 1'b0;
      i_rst = 1'b0;

      do_run(M_TABLE, 8'h80, 2, 8'd5, 1'b0);
      do_run(M_FULL,  8'h40, 0, 8'd4, 1'b0);
      do_run(M_UNDER, 8'h10, 3, 8'd6, 1'b0);
      do_run(M_RAND,  8'hC0, 1, 8'd6, 1'b1);
      do_run(M_RAND,  8'h55, -1, 8'd0, 1'b0);
      do_run(M_RAND,  8'h20, 4, 8'd6, 1'b0);
      for (int k = 0; k < 4; k++) begin
         logic [7:0] c;
         c = 8'($urandom_range(1, 3));
         do_run(M_RAND, 8'($urandom_range(0, 255)), $urandom_range(0, 5), c, k[0]);
      end

      // Reset in the middle of a stream
      kick(8'h80, 1'b0);
      repeat (5) begin
         @(negedge clk);
         i_blob_sdram_req = 1'b1;
         i_rd_valid = 1'b0;
      end
      @(negedge clk);
      i_rst = 1'b1;
      #1;
      model_reset();
      check("rst_mid_valid", o_blob_valid, 0);
      check("rst_mid_gnt", o_vga_gnt, 1);
      check("rst_mid_count", o_count, exp_count);
      check("rst_mid_rd_req", o_rd_req, 0);
      @(negedge clk);
      i_rst = 1'b0;
      i_blob_sdram_req = 1'b0;
      @(negedge clk);
      check_reset_state("post_rst");

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
